// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for an N x N systolic array: skews paired A/B beats onto the west/north
// edges, flushes the grid, requests the drain and collects the N result rows.
package pe_pkg;
    localparam int DATA_WIDTH = 8;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } matrix_data_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  enable;
    } drain_data_t;
endpackage

module systolic_seq_ctrl #(
    parameter int N          = 4,
    parameter int K_MAX      = 16,
    parameter int DATA_WIDTH = pe_pkg::DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [$clog2(K_MAX+1)-1:0]    k_len_i,
    output logic                          busy_o,
    output logic                          done_o,
    input  logic                          a_valid_i,
    output logic                          a_ready_o,
    input  logic [N*DATA_WIDTH-1:0]       a_data_i,
    input  logic                          b_valid_i,
    output logic                          b_ready_o,
    input  logic [N*DATA_WIDTH-1:0]       b_data_i,
    output pe_pkg::matrix_data_t [N-1:0]  row_o,
    output pe_pkg::matrix_data_t [N-1:0]  col_o,
    output logic                          drain_req_o,
    input  pe_pkg::drain_data_t [N-1:0]   drain_i,
    output logic                          res_valid_o,
    output logic [N*DATA_WIDTH-1:0]       res_data_o,
    output logic [$clog2(N)-1:0]          res_row_o
);
    localparam int KW = $clog2(K_MAX+1);
    localparam int CW = $clog2(2*N);
    localparam int RW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [KW-1:0]           r_k;
    logic [KW-1:0]           r_kcnt;
    logic [CW-1:0]           r_cnt;
    logic [RW-1:0]           r_row;
    logic                    r_done;
    logic                    r_res_valid;
    logic [N*DATA_WIDTH-1:0] r_res_data;
    logic [RW-1:0]           r_res_row;

    logic                    w_start;
    logic [KW-1:0]           w_k_clip;
    logic                    w_more;
    logic                    w_xfer;
    logic                    w_last;
    logic                    w_capture;
    logic                    w_last_row;
    logic [N*DATA_WIDTH-1:0] w_drain_data;
    logic [N-1:0]            w_unused_en;

    // The done cycle still belongs to the job, so a start seen alongside done_o is ignored.
    assign w_start    = (r_state == S_IDLE) && start_i && !r_done;
    assign w_k_clip   = (k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : k_len_i;
    assign w_more     = (r_kcnt < r_k);
    assign a_ready_o  = (r_state == S_FEED) && b_valid_i && w_more;
    assign b_ready_o  = (r_state == S_FEED) && a_valid_i && w_more;
    assign w_xfer     = (r_state == S_FEED) && a_valid_i && b_valid_i && w_more;
    assign w_last     = (r_kcnt == (r_k - KW'(1)));
    assign w_capture  = ((r_state == S_DRAIN) || (r_state == S_COLLECT)) && drain_i[0].enable;
    assign w_last_row = w_capture && (r_row == RW'(N-1));

    assign busy_o      = (r_state != S_IDLE) || r_done;
    assign done_o      = r_done;
    assign drain_req_o = (r_state == S_DRAIN);
    assign res_valid_o = r_res_valid;
    assign res_data_o  = r_res_data;
    assign res_row_o   = r_res_row;

    always_comb begin
        w_drain_data = '0;
        w_unused_en  = '0;
        for (int j = 0; j < N; j++) begin
            w_drain_data[j*DATA_WIDTH +: DATA_WIDTH] = drain_i[j].data;
            w_unused_en[j]                          = drain_i[j].enable;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = (w_k_clip == '0) ? S_DONE : S_FEED;
                end
            end
            S_FEED: begin
                if (w_xfer && w_last) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_cnt == CW'(2*N-1)) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_row) begin
                    w_next = S_DONE;
                end else if (r_cnt == CW'(N-1)) begin
                    w_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_last_row) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_kcnt      <= '0;
            r_cnt       <= '0;
            r_row       <= '0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_row   <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_DONE);
            if (w_start) begin
                r_k    <= w_k_clip;
                r_kcnt <= '0;
                r_row  <= '0;
            end else begin
                if (w_xfer) begin
                    r_kcnt <= r_kcnt + KW'(1);
                end
                if (w_capture) begin
                    r_row <= r_row + RW'(1);
                end
            end
            // Phase counter restarts on every state change and times FLUSH and DRAIN.
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == S_FLUSH) || (r_state == S_DRAIN)) begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_res_valid <= w_capture;
            if (w_capture) begin
                r_res_data <= w_drain_data;
                r_res_row  <= r_row;
            end
        end
    end

    // Lane i gets i+1 register stages so beat k reaches lane i exactly i cycles after lane 0.
    for (genvar i = 0; i < N; i++) begin : g_lane
        pe_pkg::matrix_data_t w_a_in;
        pe_pkg::matrix_data_t w_b_in;
        pe_pkg::matrix_data_t r_a_dly [i+1];
        pe_pkg::matrix_data_t r_b_dly [i+1];

        assign w_a_in = w_xfer ? {a_data_i[i*DATA_WIDTH +: DATA_WIDTH], w_last} : '0;
        assign w_b_in = w_xfer ? {b_data_i[i*DATA_WIDTH +: DATA_WIDTH], w_last} : '0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= i; s++) begin
                    r_a_dly[s] <= '0;
                    r_b_dly[s] <= '0;
                end
            end else begin
                r_a_dly[0] <= w_a_in;
                r_b_dly[0] <= w_b_in;
                for (int s = 1; s <= i; s++) begin
                    r_a_dly[s] <= r_a_dly[s-1];
                    r_b_dly[s] <= r_b_dly[s-1];
                end
            end
        end

        assign row_o[i] = r_a_dly[i];
        assign col_o[i] = r_b_dly[i];
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: skew timing, joint handshake, K clipping,
// flush/drain timing, row collection and asynchronous reset.
module tb_systolic_seq_ctrl;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int KW = 5;

    logic                         clk       = 1'b0;
    logic                         rst_n     = 1'b0;
    logic                         start_i   = 1'b0;
    logic [KW-1:0]                k_len_i   = '0;
    logic                         busy_o;
    logic                         done_o;
    logic                         a_valid_i = 1'b0;
    logic                         a_ready_o;
    logic [N*DW-1:0]              a_data_i  = '0;
    logic                         b_valid_i = 1'b0;
    logic                         b_ready_o;
    logic [N*DW-1:0]              b_data_i  = '0;
    pe_pkg::matrix_data_t [N-1:0] row_o;
    pe_pkg::matrix_data_t [N-1:0] col_o;
    logic                         drain_req_o;
    pe_pkg::drain_data_t [N-1:0]  drain_i   = '0;
    logic                         res_valid_o;
    logic [N*DW-1:0]              res_data_o;
    logic [1:0]                   res_row_o;

    int tests = 0;
    int fails = 0;

    systolic_seq_ctrl #(.N(N), .K_MAX(16), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .k_len_i(k_len_i),
        .busy_o(busy_o), .done_o(done_o),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_data_i(b_data_i),
        .row_o(row_o), .col_o(col_o), .drain_req_o(drain_req_o), .drain_i(drain_i),
        .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_row_o(res_row_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] aval(int i, int k);
        return 8'((i + 1) * 16 + k);
    endfunction

    function automatic logic [7:0] bval(int i, int k);
        return 8'((i + 8) * 16 + k);
    endfunction

    function automatic logic [N*DW-1:0] rowval(int r);
        logic [N*DW-1:0] v;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = 8'(17 * (r + 1) + j);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(int k);
        for (int i = 0; i < N; i++) begin
            a_data_i[i*DW +: DW] = aval(i, k);
            b_data_i[i*DW +: DW] = bval(i, k);
        end
    endtask

    task automatic reset_dut();
        start_i = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0;
        a_data_i = '0; b_data_i = '0; drain_i = '0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_job(logic [KW-1:0] k);
        start_i = 1'b1;
        k_len_i = k;
        tick();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({busy_o, done_o, a_ready_o, b_ready_o, drain_req_o, res_valid_o} !== 6'b0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: got %b required 000000",
                     {busy_o, done_o, a_ready_o, b_ready_o, drain_req_o, res_valid_o});
        end
        tests++;
        if (row_o !== '0 || col_o !== '0 || res_data_o !== '0 || res_row_o !== '0) begin
            fails++;
            $display("[TB] FAIL reset_data: row %h col %h res %h idx %0d required all 0",
                     row_o, col_o, res_data_o, res_row_o);
        end
        reset_dut();
    endtask

    task automatic test_skew();
        pe_pkg::matrix_data_t exp_a, exp_b;
        logic exp_rdy;
        int b;
        reset_dut();
        start_job(5'd4);
        for (int e = 0; e < 8; e++) begin
            if (e < 4) begin
                set_beat(e); a_valid_i = 1'b1; b_valid_i = 1'b1;
            end else begin
                a_valid_i = 1'b0; b_valid_i = 1'b0;
            end
            #1;
            exp_rdy = (e < 4);
            tests++;
            if (a_ready_o !== exp_rdy || b_ready_o !== exp_rdy) begin
                fails++;
                $display("[TB] FAIL skew_ready e=%0d: got %b%b required %b%b",
                         e, a_ready_o, b_ready_o, exp_rdy, exp_rdy);
            end
            tick();
            for (int i = 0; i < N; i++) begin
                b = e - i;
                if (b >= 0 && b < 4) begin
                    exp_a = {aval(i, b), (b == 3)};
                    exp_b = {bval(i, b), (b == 3)};
                end else begin
                    exp_a = '0;
                    exp_b = '0;
                end
                tests++;
                if (row_o[i] !== exp_a || col_o[i] !== exp_b) begin
                    fails++;
                    $display("[TB] FAIL skew_lane e=%0d i=%0d: row %h col %h required %h %h",
                             e, i, row_o[i], col_o[i], exp_a, exp_b);
                end
            end
        end
    endtask

    task automatic test_toggle();
        pe_pkg::matrix_data_t exp_a, exp_b;
        logic exp_ar, exp_br;
        reset_dut();
        start_job(5'd4);
        b_valid_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            a_valid_i = (c % 2 == 0);
            set_beat(c / 2);
            if (c % 2 == 1) a_data_i = '1;
            #1;
            exp_ar = (c < 7);
            exp_br = (c < 7) && (c % 2 == 0);
            tests++;
            if (a_ready_o !== exp_ar || b_ready_o !== exp_br) begin
                fails++;
                $display("[TB] FAIL toggle_ready c=%0d: got %b%b required %b%b",
                         c, a_ready_o, b_ready_o, exp_ar, exp_br);
            end
            tick();
            if (c % 2 == 0) begin
                exp_a = {aval(0, c / 2), (c == 6)};
                exp_b = {bval(0, c / 2), (c == 6)};
            end else begin
                exp_a = '0;
                exp_b = '0;
            end
            tests++;
            if (row_o[0] !== exp_a || col_o[0] !== exp_b) begin
                fails++;
                $display("[TB] FAIL toggle_lane0 c=%0d: row %h col %h required %h %h",
                         c, row_o[0], col_o[0], exp_a, exp_b);
            end
        end
        a_valid_i = 1'b0; b_valid_i = 1'b0;
    endtask

    task automatic test_k_zero();
        logic exp_done, exp_busy;
        reset_dut();
        a_valid_i = 1'b1; b_valid_i = 1'b1;
        start_i = 1'b1; k_len_i = 5'd0;
        tick();
        start_i = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            exp_done = (c == 2);
            exp_busy = (c <= 2);
            tests++;
            if (done_o !== exp_done || busy_o !== exp_busy) begin
                fails++;
                $display("[TB] FAIL kzero_done c=%0d: done %b busy %b required %b %b",
                         c, done_o, busy_o, exp_done, exp_busy);
            end
            tests++;
            if ({a_ready_o, b_ready_o, drain_req_o, res_valid_o} !== 4'b0) begin
                fails++;
                $display("[TB] FAIL kzero_quiet c=%0d: got %b required 0000",
                         c, {a_ready_o, b_ready_o, drain_req_o, res_valid_o});
            end
            tick();
        end
        a_valid_i = 1'b0; b_valid_i = 1'b0;
    endtask

    task automatic test_k_clip();
        int xfers = 0;
        int lasts = 0;
        logic [7:0] last_data = '0;
        reset_dut();
        start_job(5'd20);
        a_valid_i = 1'b1; b_valid_i = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            set_beat(xfers);
            start_i = (cyc == 3);
            k_len_i = (cyc == 3) ? 5'd2 : 5'd20;
            #1;
            if (a_ready_o && b_ready_o) xfers++;
            tick();
            if (row_o[0].last) begin
                lasts++;
                last_data = row_o[0].data;
            end
        end
        start_i = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0;
        tests++;
        if (xfers != 16) begin
            fails++;
            $display("[TB] FAIL kclip_transfers: got %0d required 16", xfers);
        end
        tests++;
        if (lasts != 1 || last_data !== aval(0, 15)) begin
            fails++;
            $display("[TB] FAIL kclip_last: count %0d data %h required 1 %h",
                     lasts, last_data, aval(0, 15));
        end
        tests++;
        if (busy_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL kclip_busy: got %b required 1", busy_o);
        end
    endtask

    task automatic test_full_job();
        logic exp_req, exp_rv, exp_done, exp_busy;
        int exp_r;
        reset_dut();
        start_job(5'd4);
        a_valid_i = 1'b1; b_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_beat(k);
            tick();
        end
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        for (int c = 0; c < 16; c++) begin
            drain_i = '0;
            case (c)
                8, 9, 11, 12: begin
                    for (int j = 0; j < N; j++) begin
                        drain_i[j].data   = rowval((c == 8) ? 0 : (c == 9) ? 1 : (c == 11) ? 2 : 3)[j*DW +: DW];
                        drain_i[j].enable = (j == 0);
                    end
                end
                10: begin
                    for (int j = 0; j < N; j++) begin
                        drain_i[j].data   = 8'hEE;
                        drain_i[j].enable = (j != 0);
                    end
                end
                13, 14: begin
                    for (int j = 0; j < N; j++) begin
                        drain_i[j].data   = 8'hEE;
                        drain_i[j].enable = 1'b1;
                    end
                end
                default: drain_i = '0;
            endcase
            #1;
            exp_req  = (c >= 8) && (c < 12);
            exp_rv   = (c == 9) || (c == 10) || (c == 12) || (c == 13);
            exp_r    = (c == 9) ? 0 : (c == 10) ? 1 : (c == 12) ? 2 : 3;
            exp_done = (c == 14);
            exp_busy = (c <= 14);
            tests++;
            if (drain_req_o !== exp_req || done_o !== exp_done || busy_o !== exp_busy) begin
                fails++;
                $display("[TB] FAIL job_ctrl c=%0d: req %b done %b busy %b required %b %b %b",
                         c, drain_req_o, done_o, busy_o, exp_req, exp_done, exp_busy);
            end
            tests++;
            if (res_valid_o !== exp_rv) begin
                fails++;
                $display("[TB] FAIL job_res_valid c=%0d: got %b required %b", c, res_valid_o, exp_rv);
            end
            if (exp_rv) begin
                tests++;
                if (res_row_o !== 2'(exp_r) || res_data_o !== rowval(exp_r)) begin
                    fails++;
                    $display("[TB] FAIL job_res_row c=%0d: idx %0d data %h required %0d %h",
                             c, res_row_o, res_data_o, exp_r, rowval(exp_r));
                end
            end
            tick();
        end
        drain_i = '0;
    endtask

    task automatic test_reset_mid();
        pe_pkg::matrix_data_t exp_a;
        reset_dut();
        start_job(5'd4);
        a_valid_i = 1'b1; b_valid_i = 1'b1;
        set_beat(0); tick();
        set_beat(1); tick();
        set_beat(2);
        #1;
        exp_a = {aval(0, 1), 1'b0};
        tests++;
        if (row_o[0] !== exp_a || a_ready_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midrst_pre: row0 %h ready %b required %h 1", row_o[0], a_ready_o, exp_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy_o, done_o, a_ready_o, b_ready_o, drain_req_o, res_valid_o} !== 6'b0
            || row_o !== '0 || col_o !== '0) begin
            fails++;
            $display("[TB] FAIL midrst_async: ctrl %b row %h col %h required all 0",
                     {busy_o, done_o, a_ready_o, b_ready_o, drain_req_o, res_valid_o}, row_o, col_o);
        end
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_job(5'd1);
        a_valid_i = 1'b1; b_valid_i = 1'b1;
        set_beat(5);
        tick();
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        exp_a = {aval(0, 5), 1'b1};
        tests++;
        if (row_o[0] !== exp_a) begin
            fails++;
            $display("[TB] FAIL midrst_new_lane0: got %h required %h", row_o[0], exp_a);
        end
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 3) begin
                exp_a = {aval(3, 5), 1'b1};
                tests++;
                if (row_o[3] !== exp_a) begin
                    fails++;
                    $display("[TB] FAIL midrst_new_lane3: got %h required %h", row_o[3], exp_a);
                end
            end
            if (e >= 7) begin
                tests++;
                if (drain_req_o !== (e == 8)) begin
                    fails++;
                    $display("[TB] FAIL midrst_new_drain e=%0d: got %b required %b",
                             e, drain_req_o, (e == 8));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_skew();
        test_toggle();
        test_k_zero();
        test_k_clip();
        test_full_job();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
